cache_refill_ctrl: RTL
======================

# cache_refill_ctrl

Sequencer for instruction-cache line refills. On a miss it issues one 4-beat AHB-Lite read burst on the downstream master port, assembles the returned words into a 128-bit line, and hands the line, its aligned address and a completion pulse to the cache array write port. It sits between the cache hit/miss logic and the downstream AHB-Lite interface. It is the only block driving downstream address and control.

## Interface
- `CACHE_LINE`, 128 — line width in bits; beats per refill = `CACHE_LINE/32` (4).
- `ADDR_W`, 32 — address width.
- `hclk` in 1 — clock.
- `hrst` in 1 — reset, asynchronous, active-high.
- `miss_req` in 1 — level; refill requested for `miss_addr`.
- `miss_addr` in `ADDR_W` — byte address of the missing word.
- `refill_busy` out 1 — controller not in IDLE.
- `refill_done` out 1 — one-cycle pulse; `refill_line`/`refill_addr` valid.
- `refill_err` out 1 — one-cycle pulse; burst aborted by ERROR response.
- `refill_line` out `CACHE_LINE` — word k at bits [32k+31:32k].
- `refill_addr` out `ADDR_W` — line-aligned address (low 4 bits zero).
- `m_haddr` out `ADDR_W`, `m_htrans` out 2, `m_hburst` out 3, `m_hsize` out 3, `m_hwrite` out 1 — AHB master address/control.
- `m_hready` in 1, `m_hresp` in 1, `m_hrdata` in 32 — AHB master response.

## Operation
- Outputs in reset: `m_htrans`=IDLE (00), `m_haddr`=0, `m_hburst`=0, `m_hsize`=3'b010, `m_hwrite`=0, `refill_busy`=0, `refill_done`=0, `refill_err`=0, `refill_line`=0, `refill_addr`=0.
- `m_hwrite` is always 0. `m_hsize` is always word (3'b010).
- States:
  - IDLE: `miss_req`=1 latches `miss_addr`, clears the beat counters, goes to BURST.
  - BURST: address phases. Beat 0 is NONSEQ, later beats are SEQ. The address advances only when `m_hready`=1. After the last address is accepted, go to DRAIN.
  - DRAIN: `m_htrans`=IDLE; wait for the last data beat.
  - DONE: pulse `refill_done`, return to IDLE.
  - ERR: `m_htrans`=IDLE; wait for `m_hready`=1, pulse `refill_err`, return to IDLE.
- Data capture: a data-phase beat is captured when `m_hready`=1 and a data phase is outstanding. Beat address offset bits [3:2] select the word slot in `refill_line`.
- Address stepping: +4 within the line, 2-bit offset, wrap at the line boundary (WRAP4 mode only).
- `miss_req` is ignored while `refill_busy`=1. The requester holds `miss_req` until done or error. If it is still high in IDLE after done, a new refill starts.
- Error handling: `m_hresp`=1 with `m_hready`=0 during any data phase causes the following:
  - The next cycle drives `m_htrans`=IDLE and cancels the remaining beats.
  - The controller enters ERR.
  - `refill_line` keeps its old value; no `refill_done` is issued.
- Reset mid-burst: the controller returns immediately to IDLE with reset output values; a partial line is never reported.

## Timing
- Address and control are registered; with `m_hready`=0 they hold stable.
- Zero wait states, `miss_req` sampled at edge 0:
  - Cycle 1: NONSEQ, addr0.
  - Cycles 2–4: SEQ, addr1–addr3; data0–data2 sampled at the ends of cycles 2–4.
  - Cycle 5: IDLE/DRAIN; data3 sampled.
  - Cycle 6: `refill_done`=1.
- Latency is 6 cycles plus one cycle per wait state.
- `refill_line` and `refill_addr` remain stable from `refill_done` until the next refill starts.
- `refill_err` is asserted in the cycle after the second ERROR cycle (`m_hready`=1, `m_hresp`=1).

## Configuration
- `CRITICAL_WORD_FIRST_EN` defined:
  - The burst is WRAP4 (`m_hburst`=3'b010) and starts at `miss_addr[31:2]`.
  - `crit_valid` (out, 1) pulses with `crit_data` (out, 32) in the cycle after beat 0 is captured.
- `CRITICAL_WORD_FIRST_EN` undefined:
  - The burst is INCR4 (3'b011) from `{miss_addr[31:4],4'h0}`.
  - The `crit_*` ports do not exist.

## Test plan
- Zero-wait INCR4 refill:
  - Stimulus: `miss_addr`=0x1000_0018; slave returns 0xA0, 0xA1, 0xA2, 0xA3.
  - Required: addresses 0x..10, 14, 18, 1C; `refill_line`=0x000000A3_000000A2_000000A1_000000A0; `refill_addr`=0x1000_0010; done at cycle 6.
- Wait states:
  - Stimulus: `m_hready` low 2 cycles on beat 1.
  - Required: `m_haddr`/`m_htrans` held stable; done at cycle 8; same line contents.
- WRAP4 critical word first, with `CRITICAL_WORD_FIRST_EN`:
  - Stimulus: `miss_addr`=0x18.
  - Required: addresses 18, 1C, 10, 14; `crit_data`=beat-0 data at cycle 3; line slots correct.
- Error on beat 2:
  - Stimulus: two-cycle ERROR response.
  - Required: `m_htrans`=IDLE after the first ERROR cycle; `refill_err` pulses once; no `refill_done`; `refill_line` unchanged.
- Reset mid-burst:
  - Stimulus: assert `hrst` during beat 1.
  - Required: outputs return to reset values asynchronously; a new `miss_req` after release gives a clean 6-cycle refill.
- Back-to-back:
  - Stimulus: `miss_req` held through done.
  - Required: the second NONSEQ appears one cycle after IDLE is re-entered; a `miss_addr` change while busy is ignored.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
`timescale 1ns/1ps
// I-cache line refill: one 4-beat AHB-Lite read burst. refill_done comes 6 cycles after miss_req plus one per wait state.
// Address/control are held while m_hready=0. CRITICAL_WORD_FIRST_EN selects WRAP4 from the missing word and adds crit_valid/crit_data.
module cache_refill_ctrl #(
   parameter int CACHE_LINE = 128,
   parameter int ADDR_W     = 32
) (
   input  logic                  hclk,
   input  logic                  hrst,
   input  logic                  miss_req,
   input  logic [ADDR_W-1:0]     miss_addr,
   output logic                  refill_busy,
   output logic                  refill_done,
   output logic                  refill_err,
   output logic [CACHE_LINE-1:0] refill_line,
   output logic [ADDR_W-1:0]     refill_addr,
`ifdef CRITICAL_WORD_FIRST_EN
   output logic                  crit_valid,
   output logic [31:0]           crit_data,
`endif
   output logic [ADDR_W-1:0]     m_haddr,
   output logic [1:0]            m_htrans,
   output logic [2:0]            m_hburst,
   output logic [2:0]            m_hsize,
   output logic                  m_hwrite,
   input  logic                  m_hready,
   input  logic                  m_hresp,
   input  logic [31:0]           m_hrdata
);
   localparam int BEATS = CACHE_LINE / 32;
   localparam int OFF_W = $clog2(BEATS);
   localparam int LSB   = OFF_W + 2;
   localparam logic [OFF_W-1:0] LAST = {OFF_W{1'b1}};
   localparam logic [OFF_W-1:0] ONE  = {{(OFF_W-1){1'b0}}, 1'b1};
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;
`ifdef CRITICAL_WORD_FIRST_EN
   localparam logic [2:0] BURST_TYPE = 3'b010;
`else
   localparam logic [2:0] BURST_TYPE = 3'b011;
`endif

   typedef enum logic [2:0] {S_IDLE, S_BURST, S_DRAIN, S_DONE, S_ERR} state_t;
   state_t state, state_nxt;

   logic [OFF_W-1:0]      addr_cnt, data_cnt, dphase_off, step_off;
   logic                  dphase, start, addr_acc, capture, err_hit;
   logic [CACHE_LINE-1:0] line_buf, line_nxt;
   logic [ADDR_W-1:0]     start_addr;
   logic                  unused_bits;

   assign m_hsize     = 3'b010;
   assign m_hwrite    = 1'b0;
   assign refill_busy = (state != S_IDLE);
   assign step_off    = m_haddr[LSB-1:2] + ONE;
   assign unused_bits = ^miss_addr[LSB-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_addr = {miss_addr[ADDR_W-1:2], 2'b00};
`else
   assign start_addr = {miss_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
`endif

   // Beat data lands in the slot named by its own address, so wrapped bursts fill correctly.
   always_comb begin
      line_nxt = line_buf;
      line_nxt[dphase_off*32 +: 32] = m_hrdata;
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      addr_acc  = 1'b0;
      err_hit   = dphase && !m_hready && m_hresp;
      capture   = dphase && m_hready;
      case (state)
         S_IDLE: begin
            if (miss_req) begin
               start     = 1'b1;
               state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (err_hit) state_nxt = S_ERR;
            else if (m_hready) begin
               addr_acc = 1'b1;
               if (addr_cnt == LAST) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (err_hit) state_nxt = S_ERR;
            else if (capture && data_cnt == LAST) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   if (m_hready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         m_haddr     <= '0;
         m_htrans    <= HT_IDLE;
         m_hburst    <= 3'b000;
         addr_cnt    <= '0;
         data_cnt    <= '0;
         dphase      <= 1'b0;
         dphase_off  <= '0;
         line_buf    <= '0;
         refill_line <= '0;
         refill_addr <= '0;
         refill_done <= 1'b0;
         refill_err  <= 1'b0;
      end else begin
         refill_done <= 1'b0;
         refill_err  <= 1'b0;
         if (start) begin
            m_haddr  <= start_addr;
            m_htrans <= HT_NONSEQ;
            m_hburst <= BURST_TYPE;
            addr_cnt <= '0;
            data_cnt <= '0;
         end
         // An accepted address opens its data phase while the previous one (if any) completes.
         if (addr_acc) begin
            dphase     <= 1'b1;
            dphase_off <= m_haddr[LSB-1:2];
            if (addr_cnt == LAST) m_htrans <= HT_IDLE;
            else begin
               m_haddr  <= {m_haddr[ADDR_W-1:LSB], step_off, 2'b00};
               m_htrans <= HT_SEQ;
               addr_cnt <= addr_cnt + ONE;
            end
         end else if (capture) dphase <= 1'b0;
         if (capture) begin
            line_buf <= line_nxt;
            data_cnt <= data_cnt + ONE;
         end
         if (err_hit) begin
            m_htrans <= HT_IDLE;
            dphase   <= 1'b0;
         end
         if (state == S_DRAIN && state_nxt == S_DONE) begin
            refill_line <= line_nxt;
            refill_addr <= {m_haddr[ADDR_W-1:LSB], {LSB{1'b0}}};
            refill_done <= 1'b1;
         end
         if (state == S_ERR && m_hready) refill_err <= 1'b1;
      end
   end

`ifdef CRITICAL_WORD_FIRST_EN
   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         crit_valid <= 1'b0;
         crit_data  <= '0;
      end else begin
         crit_valid <= capture && data_cnt == '0;
         if (capture && data_cnt == '0) crit_data <= m_hrdata;
      end
   end
`endif
endmodule
